systolic_tile_sequencer: RTL and testbench

Control block for the N×N INT8 systolic array. It runs one output-tile computation: it clears the PE accumulators, issues K operand-buffer reads (stalling on buffer back-pressure), drives the per-row/per-column edge valid lines with the diagonal skew, waits out the array drain latency, and signals that all N×N accumulators hold final results. It sits between the host/command logic and the operand buffers/array. Operand data skewing is done in the feeder; this block owns valid, accumulator reset and timing.

---
 rtl/systolic_tile_sequencer_if.sv | 27 ++
 rtl/systolic_tile_sequencer.sv | 94 +++++++++
 tb/tb_systolic_tile_sequencer.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/systolic_tile_sequencer_if.sv
// Control bundle between host/command logic, the tile sequencer and the operand feed path.
interface systolic_tile_sequencer_if #(
  parameter int N       = 16,
  parameter int K_WIDTH = 16
);
  logic               start;
  logic [K_WIDTH-1:0] k_len;
  logic               abort;
  logic               feed_ready;
  logic               busy;
  logic               accum_reset;
  logic               rd_en;
  logic [K_WIDTH-1:0] rd_addr;
  logic [N-1:0]       row_valid;
  logic [N-1:0]       col_valid;
  logic               done;

  modport master (
    output start, k_len, abort, feed_ready,
    input  busy, accum_reset, rd_en, rd_addr, row_valid, col_valid, done
  );

  modport slave (
    input  start, k_len, abort, feed_ready,
    output busy, accum_reset, rd_en, rd_addr, row_valid, col_valid, done
  );
endinterface

// File: rtl/systolic_tile_sequencer.sv
// Sequences one output tile: clear, K skewed operand reads, drain, done. done arrives
// k_len + 2N + 1 cycles after start plus one cycle per feed_ready stall.
module systolic_tile_sequencer #(
  parameter int N       = 16,
  parameter int K_WIDTH = 16
) (
  input logic clk,
  input logic rst,
  systolic_tile_sequencer_if.slave ctl
);
  localparam int DW = $clog2(2 * N);
  localparam logic [DW-1:0] DRAIN_LAST = DW'(2 * N - 2);

  typedef enum logic [2:0] {IDLE, CLEAR, FEED, DRAIN, DONE} state_t;

  state_t             state;
  logic [K_WIDTH-1:0] k_lat;
  logic [K_WIDTH-1:0] issue_cnt;
  logic [DW-1:0]      drain_cnt;
  logic [N-1:0]       skew;
  logic               busy_r;
  logic               accum_reset_r;
  logic               done_r;
  logic               rd_en_c;

  // Read strobe follows buffer readiness combinationally so a stall costs no extra cycle.
  assign rd_en_c = (state == FEED) && ctl.feed_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      k_lat         <= '0;
      issue_cnt     <= '0;
      drain_cnt     <= '0;
      skew          <= '0;
      busy_r        <= 1'b0;
      accum_reset_r <= 1'b0;
      done_r        <= 1'b0;
    end else if (ctl.abort && (state != IDLE)) begin
      state         <= IDLE;
      skew          <= '0;
      busy_r        <= 1'b0;
      accum_reset_r <= 1'b0;
      done_r        <= 1'b0;
    end else begin
      // Bit i is the read strobe delayed 1+i cycles: one-cycle buffer latency plus diagonal skew.
      skew          <= {skew[N-2:0], rd_en_c};
      accum_reset_r <= 1'b0;
      done_r        <= 1'b0;
      case (state)
        IDLE: begin
          if (ctl.start && (ctl.k_len != '0)) begin
            k_lat         <= ctl.k_len;
            issue_cnt     <= '0;
            drain_cnt     <= '0;
            busy_r        <= 1'b1;
            accum_reset_r <= 1'b1;
            state         <= CLEAR;
          end
        end
        CLEAR: state <= FEED;
        FEED: begin
          if (rd_en_c) begin
            issue_cnt <= issue_cnt + K_WIDTH'(1);
            if (issue_cnt == k_lat - K_WIDTH'(1)) begin
              state <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (drain_cnt == DRAIN_LAST) begin
            done_r <= 1'b1;
            state  <= DONE;
          end else begin
            drain_cnt <= drain_cnt + DW'(1);
          end
        end
        DONE: begin
          busy_r <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign ctl.busy        = busy_r;
  assign ctl.accum_reset = accum_reset_r;
  assign ctl.rd_en       = rd_en_c;
  assign ctl.rd_addr     = issue_cnt;
  assign ctl.row_valid   = skew;
  assign ctl.col_valid   = skew;
  assign ctl.done        = done_r;
endmodule

// File: tb/tb_systolic_tile_sequencer.sv
// Scoreboard bench: tiles are planned as event lists from the timing rules, a negedge monitor checks the DUT against them.
module tb_systolic_tile_sequencer;
  localparam int N    = 16;
  localparam int KW   = 16;
  localparam int MAXC = 8192;
  localparam int NONE = 1 << 30;

  typedef struct {
    int cyc;
    int addr;
  } rd_ev_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  bit   mon_on = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   last_done_cyc = -1;

  bit         fr_sched [MAXC];
  rd_ev_t     exp_rd [$];
  int         exp_acc [$];
  int         exp_done [$];
  bit [N-1:0] exp_valid [int];
  bit         exp_busy [int];

  systolic_tile_sequencer_if #(.N(N), .K_WIDTH(KW)) ctl ();

  systolic_tile_sequencer #(.N(N), .K_WIDTH(KW)) dut (
    .clk (clk),
    .rst (rst),
    .ctl (ctl)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(string name, longint act, longint expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, expv);
    end
  endfunction

  function automatic bit [N-1:0] valid_at(int c);
    return exp_valid.exists(c) ? exp_valid[c] : '0;
  endfunction

  function automatic bit busy_at(int c);
    return exp_busy.exists(c) ? exp_busy[c] : 1'b0;
  endfunction

  // Reads take the first k ready cycles from s+2; each read lights lane i at read+1+i;
  // done lands 2N cycles after the last read. Anything after cut-off cycle a is dropped.
  function automatic int plan(int s, int k, int a);
    int c, n, dn, last;
    bit [N-1:0] tmp;
    exp_acc.push_back(s + 1);
    c = s + 2;
    n = 0;
    while (n < k) begin
      if (fr_sched[c]) begin
        if (c <= a) exp_rd.push_back(rd_ev_t'{cyc: c, addr: n});
        for (int i = 0; i < N; i++) begin
          if (c + 1 + i <= a) begin
            tmp = valid_at(c + 1 + i);
            tmp[i] = 1'b1;
            exp_valid[c + 1 + i] = tmp;
          end
        end
        n++;
      end
      c++;
    end
    dn = (c - 1) + 2 * N;
    if (dn <= a) exp_done.push_back(dn);
    last = (dn < a) ? dn : a;
    for (int t = s + 1; t <= last; t++) exp_busy[t] = 1'b1;
    return dn;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_until(int c);
    while (cyc < c) step();
  endtask

  task automatic start_tile(input int k, input int a, output int s, output int dn);
    s  = cyc;
    dn = plan(s, k, a);
    ctl.start = 1'b1;
    ctl.k_len = KW'(k);
    step();
    ctl.start = 1'b0;
    ctl.k_len = KW'($urandom);
  endtask

  task automatic abort_at(int a);
    wait_until(a);
    ctl.abort = 1'b1;
    step();
    ctl.abort = 1'b0;
  endtask

  // Feed-ready driver replays the planned schedule so the model and DUT see the same stalls.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      ctl.feed_ready = fr_sched[cyc];
    end
  end

  always @(negedge clk) begin
    if (mon_on) begin
      while (exp_rd.size() > 0 && exp_rd[0].cyc < cyc) begin
        chk("rd_missed", cyc, exp_rd[0].cyc);
        void'(exp_rd.pop_front());
      end
      if (ctl.rd_en) begin
        if (exp_rd.size() == 0) chk("rd_unexpected", ctl.rd_en, 0);
        else begin
          chk("rd_cycle", cyc, exp_rd[0].cyc);
          chk("rd_addr", ctl.rd_addr, exp_rd[0].addr);
          void'(exp_rd.pop_front());
        end
      end
      while (exp_acc.size() > 0 && exp_acc[0] < cyc) begin
        chk("accum_missed", cyc, exp_acc[0]);
        void'(exp_acc.pop_front());
      end
      if (ctl.accum_reset) begin
        if (exp_acc.size() == 0) chk("accum_unexpected", ctl.accum_reset, 0);
        else begin
          chk("accum_cycle", cyc, exp_acc[0]);
          void'(exp_acc.pop_front());
        end
      end
      while (exp_done.size() > 0 && exp_done[0] < cyc) begin
        chk("done_missed", cyc, exp_done[0]);
        void'(exp_done.pop_front());
      end
      if (ctl.done) begin
        last_done_cyc <= cyc;
        if (exp_done.size() == 0) chk("done_unexpected", ctl.done, 0);
        else begin
          chk("done_cycle", cyc, exp_done[0]);
          void'(exp_done.pop_front());
        end
      end
      chk("row_valid", ctl.row_valid, valid_at(cyc));
      chk("col_valid", ctl.col_valid, valid_at(cyc));
      chk("busy", ctl.busy, busy_at(cyc));
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete at cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int s, dn, s2, dn2, a, k, gap;
    for (int c = 0; c < MAXC; c++) fr_sched[c] = 1'b1;
    ctl.start      = 1'b0;
    ctl.k_len      = '0;
    ctl.abort      = 1'b0;
    ctl.feed_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst    = 1'b0;
    mon_on = 1'b1;
    @(negedge clk);
    chk("reset_rd_addr", ctl.rd_addr, 0);
    chk("reset_rd_en", ctl.rd_en, 0);
    chk("reset_done", ctl.done, 0);
    step();

    // Plain tile, k_len=4.
    start_tile(4, NONE, s, dn);
    wait_until(dn + 1);
    chk("k4_done_latency", last_done_cyc, s + 37);

    // Same tile with buffer stalls two and three cycles after start+1.
    fr_sched[cyc + 3] = 1'b0;
    fr_sched[cyc + 4] = 1'b0;
    start_tile(4, NONE, s, dn);
    wait_until(s + 3);
    @(negedge clk);
    chk("stall_addr_hold", ctl.rd_addr, 1);
    step();
    wait_until(dn + 1);
    chk("k4_stall_done_latency", last_done_cyc, s + 39);

    // Zero-length start must be ignored.
    ctl.start = 1'b1;
    ctl.k_len = '0;
    step();
    ctl.start = 1'b0;
    repeat (3) step();

    // Start during FEED is ignored.
    start_tile(8, NONE, s, dn);
    wait_until(s + 5);
    ctl.start = 1'b1;
    ctl.k_len = KW'(3);
    step();
    ctl.start = 1'b0;
    wait_until(dn + 1);

    // Abort mid-FEED, then restart one cycle later.
    a = cyc + 10;
    start_tile(20, a, s, dn);
    abort_at(a);
    step();
    start_tile(3, NONE, s, dn);
    wait_until(dn + 1);

    // Synchronous reset during DRAIN.
    a = cyc + 12;
    start_tile(5, a, s, dn);
    wait_until(a);
    rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_rd_addr", ctl.rd_addr, 0);
    chk("rst_rd_en", ctl.rd_en, 0);
    chk("rst_accum_reset", ctl.accum_reset, 0);
    chk("rst_done", ctl.done, 0);
    step();

    // Back-to-back single-k tiles.
    start_tile(1, NONE, s, dn);
    wait_until(dn + 1);
    chk("b2b_first_done", last_done_cyc, s + 34);
    start_tile(1, NONE, s2, dn2);
    wait_until(dn2 + 1);
    chk("b2b_second_done", last_done_cyc, s + 69);

    // Random tiles with random stalls and occasional aborts.
    for (int t = 0; t < 10; t++) begin
      k = $urandom_range(1, 40);
      for (int c = cyc + 2; c < cyc + 2 + 3 * k + 4; c++) fr_sched[c] = ($urandom_range(0, 9) < 7);
      a = ($urandom_range(0, 3) == 0) ? cyc + $urandom_range(1, k + 2 * N + 1) : NONE;
      start_tile(k, a, s, dn);
      if (a != NONE) abort_at(a);
      else wait_until(dn + 1);
      gap = $urandom_range(0, 3);
      repeat (gap) step();
    end

    repeat (3) step();
    chk("reads_left", exp_rd.size(), 0);
    chk("accum_left", exp_acc.size(), 0);
    chk("done_left", exp_done.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
